register_read_arbiter: RTL

- Shares the two synchronous read ports of the register file between dual-issue decode lanes A and B.
- Each lane needs up to two source operands, so one bundle needs up to four reads.
- When demand exceeds two reads, the arbiter splits the bundle over two issue cycles.
- It raises registerAStall_o/registerBStall_o to the pipeline stall unit so decode holds the bundle, then returns both lanes' operands together.

---
 rtl/register_read_arbiter_pkg.sv | 48 ++++
 rtl/register_read_arbiter_if.sv | 50 +++++
 rtl/read_slot_selector.sv | 37 +++
 rtl/register_read_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/register_read_arbiter_pkg.sv
// Shared types and constants for the register-file read arbiter.
package register_read_arbiter_pkg;

  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned SLOT_W    = 2;
  localparam int unsigned CNT_W     = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    PHASE2 = 1'b1
  } state_e;

  // Slot order follows program order across the two decode lanes
  localparam logic [SLOT_W-1:0] SLOT_A1 = 2'd0;
  localparam logic [SLOT_W-1:0] SLOT_A2 = 2'd1;
  localparam logic [SLOT_W-1:0] SLOT_B1 = 2'd2;
  localparam logic [SLOT_W-1:0] SLOT_B2 = 2'd3;

  typedef struct packed {
    logic              valid;
    logic              op1_en;
    logic              op2_en;
    logic [ADDR_W-1:0] op1_addr;
    logic [ADDR_W-1:0] op2_addr;
  } lane_req_t;

  function automatic logic [NUM_SLOTS-1:0] live_mask(input lane_req_t a, input lane_req_t b);
    logic [NUM_SLOTS-1:0] m;
    m          = '0;
    m[SLOT_A1] = a.valid & a.op1_en;
    m[SLOT_A2] = a.valid & a.op2_en;
    m[SLOT_B1] = b.valid & b.op1_en;
    m[SLOT_B2] = b.valid & b.op2_en;
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] live_count(input logic [NUM_SLOTS-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      c = c + CNT_W'(m[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/register_read_arbiter_if.sv
// Decode-lane, register-file and stall-unit signals of the read arbiter.
interface register_read_arbiter_if;
  import register_read_arbiter_pkg::*;

  logic              laneAValid_i;
  logic              laneAOp1En_i;
  logic              laneAOp2En_i;
  logic [ADDR_W-1:0] laneAOp1Addr_i;
  logic [ADDR_W-1:0] laneAOp2Addr_i;
  logic              laneBValid_i;
  logic              laneBOp1En_i;
  logic              laneBOp2En_i;
  logic [ADDR_W-1:0] laneBOp1Addr_i;
  logic [ADDR_W-1:0] laneBOp2Addr_i;
  logic              rfPort0En_o;
  logic              rfPort1En_o;
  logic [ADDR_W-1:0] rfPort0Addr_o;
  logic [ADDR_W-1:0] rfPort1Addr_o;
  logic [DATA_W-1:0] rfPort0Data_i;
  logic [DATA_W-1:0] rfPort1Data_i;
  logic              laneAOutValid_o;
  logic              laneBOutValid_o;
  logic [DATA_W-1:0] laneAOp1Data_o;
  logic [DATA_W-1:0] laneAOp2Data_o;
  logic [DATA_W-1:0] laneBOp1Data_o;
  logic [DATA_W-1:0] laneBOp2Data_o;
  logic              registerAStall_o;
  logic              registerBStall_o;

  modport slave (
    input  laneAValid_i, laneAOp1En_i, laneAOp2En_i, laneAOp1Addr_i, laneAOp2Addr_i,
    input  laneBValid_i, laneBOp1En_i, laneBOp2En_i, laneBOp1Addr_i, laneBOp2Addr_i,
    input  rfPort0Data_i, rfPort1Data_i,
    output rfPort0En_o, rfPort1En_o, rfPort0Addr_o, rfPort1Addr_o,
    output laneAOutValid_o, laneBOutValid_o,
    output laneAOp1Data_o, laneAOp2Data_o, laneBOp1Data_o, laneBOp2Data_o,
    output registerAStall_o, registerBStall_o
  );

  modport master (
    output laneAValid_i, laneAOp1En_i, laneAOp2En_i, laneAOp1Addr_i, laneAOp2Addr_i,
    output laneBValid_i, laneBOp1En_i, laneBOp2En_i, laneBOp1Addr_i, laneBOp2Addr_i,
    output rfPort0Data_i, rfPort1Data_i,
    input  rfPort0En_o, rfPort1En_o, rfPort0Addr_o, rfPort1Addr_o,
    input  laneAOutValid_o, laneBOutValid_o,
    input  laneAOp1Data_o, laneAOp2Data_o, laneBOp1Data_o, laneBOp2Data_o,
    input  registerAStall_o, registerBStall_o
  );

endinterface

// File: rtl/read_slot_selector.sv
// Picks the first two live slots (or the third and fourth when skipping) in slot order.
module read_slot_selector
  import register_read_arbiter_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] live_mask_i,
  input  logic                 skip_first_two_i,
  output logic                 sel0_vld_c,
  output logic [SLOT_W-1:0]    sel0_slot_c,
  output logic                 sel1_vld_c,
  output logic [SLOT_W-1:0]    sel1_slot_c
);

  logic [CNT_W-1:0] first_rank;
  logic [CNT_W-1:0] rank;

  always_comb begin
    sel0_vld_c  = 1'b0;
    sel0_slot_c = '0;
    sel1_vld_c  = 1'b0;
    sel1_slot_c = '0;
    first_rank  = skip_first_two_i ? CNT_W'(2) : CNT_W'(0);
    rank        = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (live_mask_i[i]) begin
        if (rank == first_rank) begin
          sel0_vld_c  = 1'b1;
          sel0_slot_c = SLOT_W'(i);
        end else if (rank == first_rank + CNT_W'(1)) begin
          sel1_vld_c  = 1'b1;
          sel1_slot_c = SLOT_W'(i);
        end
        rank = rank + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/register_read_arbiter.sv
// Shares two synchronous register-file read ports between two decode lanes,
// splitting bundles needing more than two reads over two issue cycles.
module register_read_arbiter
  import register_read_arbiter_pkg::*;
(
  input logic                   clock_i,
  input logic                   reset_i,
  register_read_arbiter_if.slave bus
);

  state_e                           state_q, state_d;
  lane_req_t                        cap_a_q, cap_a_d, cap_b_q, cap_b_d;
  logic                             ret0_vld_q, ret0_vld_d, ret1_vld_q, ret1_vld_d;
  logic [SLOT_W-1:0]                ret0_slot_q, ret0_slot_d, ret1_slot_q, ret1_slot_d;
  logic                             out_a_vld_q, out_a_vld_d, out_b_vld_q, out_b_vld_d;
  logic [NUM_SLOTS-1:0][DATA_W-1:0] op_q, op_d;

  lane_req_t            lane_a_c, lane_b_c, src_a_c, src_b_c;
  logic [NUM_SLOTS-1:0] live_c;
  logic                 sel0_vld_c, sel1_vld_c;
  logic [SLOT_W-1:0]    sel0_slot_c, sel1_slot_c;
  logic                 port0_en_c, port1_en_c, stall_c;
  logic [ADDR_W-1:0]    port0_addr_c, port1_addr_c;

  assign lane_a_c = '{valid: bus.laneAValid_i, op1_en: bus.laneAOp1En_i, op2_en: bus.laneAOp2En_i,
                      op1_addr: bus.laneAOp1Addr_i, op2_addr: bus.laneAOp2Addr_i};
  assign lane_b_c = '{valid: bus.laneBValid_i, op1_en: bus.laneBOp1En_i, op2_en: bus.laneBOp2En_i,
                      op1_addr: bus.laneBOp1Addr_i, op2_addr: bus.laneBOp2Addr_i};

  // Second phase works only from the captured bundle; live lane inputs are ignored
  assign src_a_c = (state_q == PHASE2) ? cap_a_q : lane_a_c;
  assign src_b_c = (state_q == PHASE2) ? cap_b_q : lane_b_c;
  assign live_c  = live_mask(src_a_c, src_b_c);

  read_slot_selector u_slot_sel (
    .live_mask_i      (live_c),
    .skip_first_two_i (state_q == PHASE2),
    .sel0_vld_c       (sel0_vld_c),
    .sel0_slot_c      (sel0_slot_c),
    .sel1_vld_c       (sel1_vld_c),
    .sel1_slot_c      (sel1_slot_c)
  );

  function automatic logic [ADDR_W-1:0] slot_addr(input logic [SLOT_W-1:0] s,
                                                  input lane_req_t a, input lane_req_t b);
    case (s)
      SLOT_A1: return a.op1_addr;
      SLOT_A2: return a.op2_addr;
      SLOT_B1: return b.op1_addr;
      default: return b.op2_addr;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    cap_a_d      = cap_a_q;
    cap_b_d      = cap_b_q;
    ret0_vld_d   = 1'b0;
    ret0_slot_d  = '0;
    ret1_vld_d   = 1'b0;
    ret1_slot_d  = '0;
    out_a_vld_d  = 1'b0;
    out_b_vld_d  = 1'b0;
    port0_en_c   = 1'b0;
    port0_addr_c = '0;
    port1_en_c   = 1'b0;
    port1_addr_c = '0;
    stall_c      = 1'b0;

    // Returning data is visible on the operand outputs in the cycle it arrives
    op_d = op_q;
    if (ret0_vld_q) op_d[ret0_slot_q] = bus.rfPort0Data_i;
    if (ret1_vld_q) op_d[ret1_slot_q] = bus.rfPort1Data_i;

    if (reset_i) begin
      port0_en_c  = sel0_vld_c;
      port1_en_c  = sel1_vld_c;
      ret0_vld_d  = sel0_vld_c;
      ret0_slot_d = sel0_slot_c;
      ret1_vld_d  = sel1_vld_c;
      ret1_slot_d = sel1_slot_c;
      if (sel0_vld_c) port0_addr_c = slot_addr(sel0_slot_c, src_a_c, src_b_c);
      if (sel1_vld_c) port1_addr_c = slot_addr(sel1_slot_c, src_a_c, src_b_c);

      case (state_q)
        IDLE: begin
          if (lane_a_c.valid || lane_b_c.valid) begin
            cap_a_d = lane_a_c;
            cap_b_d = lane_b_c;
          end
          if (live_count(live_c) > CNT_W'(2)) begin
            stall_c = 1'b1;
            state_d = PHASE2;
          end else begin
            out_a_vld_d = lane_a_c.valid;
            out_b_vld_d = lane_b_c.valid;
          end
        end
        PHASE2: begin
          state_d     = IDLE;
          out_a_vld_d = cap_a_q.valid;
          out_b_vld_d = cap_b_q.valid;
        end
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      cap_a_q     <= '0;
      cap_b_q     <= '0;
      ret0_vld_q  <= 1'b0;
      ret0_slot_q <= '0;
      ret1_vld_q  <= 1'b0;
      ret1_slot_q <= '0;
      out_a_vld_q <= 1'b0;
      out_b_vld_q <= 1'b0;
      op_q        <= '0;
    end else begin
      state_q     <= state_d;
      cap_a_q     <= cap_a_d;
      cap_b_q     <= cap_b_d;
      ret0_vld_q  <= ret0_vld_d;
      ret0_slot_q <= ret0_slot_d;
      ret1_vld_q  <= ret1_vld_d;
      ret1_slot_q <= ret1_slot_d;
      out_a_vld_q <= out_a_vld_d;
      out_b_vld_q <= out_b_vld_d;
      op_q        <= op_d;
    end
  end

  assign bus.rfPort0En_o      = port0_en_c;
  assign bus.rfPort0Addr_o    = port0_addr_c;
  assign bus.rfPort1En_o      = port1_en_c;
  assign bus.rfPort1Addr_o    = port1_addr_c;
  assign bus.registerAStall_o = stall_c;
  assign bus.registerBStall_o = stall_c;
  assign bus.laneAOutValid_o  = out_a_vld_q;
  assign bus.laneBOutValid_o  = out_b_vld_q;
  assign bus.laneAOp1Data_o   = op_d[SLOT_A1];
  assign bus.laneAOp2Data_o   = op_d[SLOT_A2];
  assign bus.laneBOp1Data_o   = op_d[SLOT_B1];
  assign bus.laneBOp2Data_o   = op_d[SLOT_B2];

endmodule
